// File: rtl/calc_entry_ctrl.sv
// Keypad entry controller: assembles two BCD operands and an operator, handshakes with the ALU.
// Optional macro CALC_CHAIN_EN lets an operator key in S_RES chain the result into a new operation.
module calc_entry_ctrl #(
    parameter int DIGITS = 6,
    parameter int CNT_W  = 4
) (
    input  logic                  CLK_1K,
    input  logic                  RST,
    input  logic [3:0]            key_value,
    input  logic                  flag,
    input  logic [4*DIGITS-1:0]   alu_result,
    input  logic                  alu_done,
    input  logic                  alu_err,
    output logic [4*DIGITS-1:0]   num_reg1,
    output logic [4*DIGITS-1:0]   num_reg2,
    output logic [3:0]            opcode,
    output logic                  alu_start,
    output logic [4*DIGITS-1:0]   num_out,
    output logic                  err,
    output logic                  digit_ovf,
    output logic [2:0]            state
);

    localparam int W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DIGITS);

    typedef enum logic [2:0] {
        S_OP1  = 3'd0,
        S_OPC  = 3'd1,
        S_OP2  = 3'd2,
        S_WAIT = 3'd3,
        S_RES  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [W-1:0]     r_reg1, r_reg2, w_reg1_nxt, w_reg2_nxt;
    logic [3:0]       r_op, w_op_nxt;
    logic [CNT_W-1:0] r_cnt1, r_cnt2, w_cnt1_nxt, w_cnt2_nxt;
    logic             r_start, w_start_nxt;
    logic             r_ovf, w_ovf_nxt;

    logic w_is_dig, w_is_op, w_is_eq, w_is_clr;

    // Shift one BCD digit into the low nibble; works down to DIGITS=1.
    function automatic logic [W-1:0] f_append(input logic [W-1:0] v, input logic [3:0] d);
        logic [W+3:0] t;
        t = {v, d};
        return t[W-1:0];
    endfunction

    // A leading zero is stored but does not consume a digit slot.
    function automatic logic [CNT_W-1:0] f_cnt_adv(input logic [CNT_W-1:0] c, input logic [3:0] d);
        if (c == '0 && d == 4'd0)
            return c;
        return c + CNT_W'(1);
    endfunction

    assign w_is_dig = flag && (key_value <= 4'd9);
    assign w_is_op  = flag && (key_value >= 4'hA) && (key_value <= 4'hD);
    assign w_is_eq  = flag && (key_value == 4'hE);
    assign w_is_clr = flag && (key_value == 4'hF);

    always_comb begin
        w_state_nxt = r_state;
        w_reg1_nxt  = r_reg1;
        w_reg2_nxt  = r_reg2;
        w_op_nxt    = r_op;
        w_cnt1_nxt  = r_cnt1;
        w_cnt2_nxt  = r_cnt2;
        w_start_nxt = 1'b0;
        w_ovf_nxt   = 1'b0;

        if (w_is_clr) begin
            // Clear overrides everything, including a simultaneous alu_done.
            w_reg1_nxt  = '0;
            w_reg2_nxt  = '0;
            w_op_nxt    = 4'd0;
            w_cnt1_nxt  = '0;
            w_cnt2_nxt  = '0;
            w_state_nxt = S_OP1;
        end else begin
            case (r_state)
                S_OP1: begin
                    if (w_is_dig) begin
                        if (r_cnt1 == FULL) begin
                            w_ovf_nxt = 1'b1;
                        end else begin
                            w_reg1_nxt = f_append(r_reg1, key_value);
                            w_cnt1_nxt = f_cnt_adv(r_cnt1, key_value);
                        end
                    end else if (w_is_op) begin
                        w_op_nxt    = key_value;
                        w_state_nxt = S_OPC;
                    end
                end
                S_OPC: begin
                    if (w_is_op) begin
                        w_op_nxt = key_value;
                    end else if (w_is_dig) begin
                        w_reg2_nxt  = W'(key_value);
                        w_cnt2_nxt  = CNT_W'(key_value != 4'd0);
                        w_state_nxt = S_OP2;
                    end
                end
                S_OP2: begin
                    if (w_is_dig) begin
                        if (r_cnt2 == FULL) begin
                            w_ovf_nxt = 1'b1;
                        end else begin
                            w_reg2_nxt = f_append(r_reg2, key_value);
                            w_cnt2_nxt = f_cnt_adv(r_cnt2, key_value);
                        end
                    end else if (w_is_eq) begin
                        w_start_nxt = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (alu_done) begin
                        if (alu_err) begin
                            w_state_nxt = S_ERR;
                        end else begin
                            // Result becomes a full first operand: further digits restart entry.
                            w_reg1_nxt  = alu_result;
                            w_reg2_nxt  = '0;
                            w_cnt1_nxt  = FULL;
                            w_state_nxt = S_RES;
                        end
                    end
                end
                S_RES: begin
                    if (w_is_dig) begin
                        w_reg1_nxt  = W'(key_value);
                        w_cnt1_nxt  = CNT_W'(key_value != 4'd0);
                        w_reg2_nxt  = '0;
                        w_op_nxt    = 4'd0;
                        w_state_nxt = S_OP1;
                    end
`ifdef CALC_CHAIN_EN
                    else if (w_is_op) begin
                        w_op_nxt    = key_value;
                        w_state_nxt = S_OPC;
                    end
`endif
                end
                S_ERR: begin
                    w_state_nxt = S_ERR;
                end
                default: begin
                    w_state_nxt = S_OP1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_1K or posedge RST) begin
        if (RST) begin
            r_state <= S_OP1;
            r_reg1  <= '0;
            r_reg2  <= '0;
            r_op    <= 4'd0;
            r_cnt1  <= '0;
            r_cnt2  <= '0;
            r_start <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_reg1  <= w_reg1_nxt;
            r_reg2  <= w_reg2_nxt;
            r_op    <= w_op_nxt;
            r_cnt1  <= w_cnt1_nxt;
            r_cnt2  <= w_cnt2_nxt;
            r_start <= w_start_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign num_reg1  = r_reg1;
    assign num_reg2  = r_reg2;
    assign opcode    = r_op;
    assign alu_start = r_start;
    assign digit_ovf = r_ovf;
    assign state     = r_state;
    assign err       = (r_state == S_ERR);
    assign num_out   = (r_state == S_OP2) ? r_reg2 :
                       (r_state == S_ERR) ? '0     : r_reg1;

endmodule
